// File: rtl/rotate_pkg.sv
// Shared definitions for the scrolling message display controller.
//   mode_t      : HOLD / RUN mode encoding
//   STREAM_LEN  : nibbles in the scroll stream (message1 then message2)
//   POS_W/NIB_W : widths of the scroll position and of one displayed digit
//   stream_nib  : picks nibble idx from the stream, nibble 0 being the MSB
package rotate_pkg;

    typedef enum logic {
        MODE_HOLD = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    localparam int STREAM_LEN = 16;
    localparam int POS_W      = 4;
    localparam int NIB_W      = 4;
    localparam int STREAM_W   = STREAM_LEN * NIB_W;

    function automatic logic [NIB_W-1:0] stream_nib(input logic [STREAM_W-1:0] s,
                                                    input logic [POS_W-1:0]    idx);
        logic [STREAM_W-1:0] sh;
        sh = s << (NIB_W * idx);
        return sh[STREAM_W-1 -: NIB_W];
    endfunction

endpackage

// File: rtl/rotate_scheduler_btn_debounce.sv
// Front-panel button conditioner.
//   clk   : system clock
//   reset : asynchronous, active-low
//   btn   : raw button level
//   press : one-cycle pulse when the accepted level goes 0 -> 1
// The accepted level follows the synchronised input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts it.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    // Pulse only on the rising acceptance.
                    press <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rotate_scheduler.sv
// Scroll sequencing controller for the four-digit message display.
//   clk, reset           : system clock, asynchronous active-low reset
//   mode_btn, step_btn   : raw buttons (RUN/HOLD toggle, single step in HOLD)
//   dir                  : 1 = forward, 0 = backward
//   msg_load             : strobe capturing message1/message2 into the pending buffer
//   message1, message2   : stream nibbles 0-7 and 8-15, MS nibble first
//   hex3..hex0           : displayed nibbles, hex0 = stream[pos]
//   pos                  : scroll position
//   running, pending     : RUN mode flag, loaded message awaiting commit
//
// state     | meaning
// MODE_HOLD | scroll frozen, prescaler frozen, step presses advance
// MODE_RUN  | prescaler runs, each tick advances, step presses ignored
module rotate_scheduler
    import rotate_pkg::*;
#(
    parameter int TICK_DIV        = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode_btn,
    input  logic             step_btn,
    input  logic             dir,
    input  logic             msg_load,
    input  logic [31:0]      message1,
    input  logic [31:0]      message2,
    output logic [NIB_W-1:0] hex3,
    output logic [NIB_W-1:0] hex2,
    output logic [NIB_W-1:0] hex1,
    output logic [NIB_W-1:0] hex0,
    output logic [POS_W-1:0] pos,
    output logic             running,
    output logic             pending
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    mode_t               mode;
    mode_t               mode_nxt;
    logic [PRE_W-1:0]    presc;
    logic                mode_press;
    logic                step_press;
    logic                tick;
    logic                advance;
    logic                commit_adv;
    logic [POS_W-1:0]    pos_nxt;
    logic [STREAM_W-1:0] incoming;
    logic [STREAM_W-1:0] active;
    logic [STREAM_W-1:0] active_nxt;
    logic                active_valid;
    logic                active_valid_nxt;
    logic [STREAM_W-1:0] pend_buf;
    logic [STREAM_W-1:0] pend_buf_nxt;
    logic                pending_nxt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .btn   (mode_btn),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk   (clk),
        .reset (reset),
        .btn   (step_btn),
        .press (step_press)
    );

    assign running  = (mode == MODE_RUN);
    assign incoming = {message1, message2};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode <= MODE_HOLD;
        end else begin
            mode <= mode_nxt;
        end
    end

    // Advance is decided by the current mode even when a mode press
    // lands in the same cycle as a tick.
    always_comb begin
        mode_nxt = mode;
        tick     = (mode == MODE_RUN) && (presc == PRE_LAST);
        advance  = (mode == MODE_RUN) ? tick : step_press;
        if (mode_press) begin
            mode_nxt = (mode == MODE_RUN) ? MODE_HOLD : MODE_RUN;
        end
    end

    always_comb begin
        pos_nxt          = pos;
        active_nxt       = active;
        active_valid_nxt = active_valid;
        pend_buf_nxt     = pend_buf;
        pending_nxt      = pending;

        if (advance) begin
            pos_nxt = dir ? pos + 1'b1 : pos - 1'b1;
        end
        commit_adv = advance && (pos_nxt == '0);

        if (commit_adv && msg_load) begin
            // Message arriving on the wrap goes straight to the display.
            active_nxt       = incoming;
            active_valid_nxt = 1'b1;
            pending_nxt      = 1'b0;
        end else begin
            if (pending && (commit_adv || !active_valid)) begin
                active_nxt       = pend_buf;
                active_valid_nxt = 1'b1;
                pending_nxt      = 1'b0;
            end
            if (msg_load) begin
                pend_buf_nxt = incoming;
                pending_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (mode == MODE_HOLD && mode_nxt == MODE_RUN) begin
            presc <= '0;
        end else if (mode == MODE_RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos          <= '0;
            active       <= '0;
            active_valid <= 1'b0;
            pend_buf     <= '0;
            pending      <= 1'b0;
            hex0         <= '0;
            hex1         <= '0;
            hex2         <= '0;
            hex3         <= '0;
        end else begin
            pos          <= pos_nxt;
            active       <= active_nxt;
            active_valid <= active_valid_nxt;
            pend_buf     <= pend_buf_nxt;
            pending      <= pending_nxt;
            hex0         <= stream_nib(active_nxt, pos_nxt);
            hex1         <= stream_nib(active_nxt, pos_nxt + 4'd1);
            hex2         <= stream_nib(active_nxt, pos_nxt + 4'd2);
            hex3         <= stream_nib(active_nxt, pos_nxt + 4'd3);
        end
    end

endmodule

// File: tb/tb_rotate_scheduler.sv
module tb_rotate_scheduler;

    localparam int TD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mode_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic        dir = 1'b1;
    logic        msg_load = 1'b0;
    logic [31:0] message1 = '0;
    logic [31:0] message2 = '0;
    logic [3:0]  hex3, hex2, hex1, hex0, pos;
    logic        running, pending;
    logic [21:0] obs;

    int total = 0;
    int bad = 0;

    // reference model state
    bit          m_run;
    int          m_pre;
    int          m_pos;
    logic [63:0] m_act;
    logic [63:0] m_pbuf;
    bit          m_valid;
    bit          m_pend;
    bit          hist[2][DB+2];
    bit          acc[2];
    bit          pul[2];

    rotate_scheduler #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .step_btn(step_btn),
        .dir(dir), .msg_load(msg_load), .message1(message1), .message2(message2),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .pos(pos), .running(running), .pending(pending)
    );

    assign obs = {hex3, hex2, hex1, hex0, pos, running, pending};

    always #5 clk = ~clk;

    function automatic logic [3:0] mnib(input logic [63:0] s, input int i);
        logic [63:0] t;
        t = s >> (4 * (15 - (i % 16)));
        return t[3:0];
    endfunction

    function automatic logic [21:0] expv();
        logic [3:0] p;
        p = 4'(m_pos);
        return {mnib(m_act, m_pos + 3), mnib(m_act, m_pos + 2), mnib(m_act, m_pos + 1),
                mnib(m_act, m_pos), p, m_run, m_pend};
    endfunction

    task automatic model_reset();
        m_run = 0; m_pre = 0; m_pos = 0; m_act = '0; m_pbuf = '0;
        m_valid = 0; m_pend = 0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DB + 2; i++) hist[b][i] = 0;
            acc[b] = 0; pul[b] = 0;
        end
    endtask

    // One rising edge of the specification's behaviour, using the inputs
    // that were stable before the edge. Button acceptance is judged on a
    // window of raw samples delayed by the two synchroniser stages.
    task automatic model_edge();
        bit tick, adv, wrap, mp, sp, all_diff, raw;
        mp = pul[0];
        sp = pul[1];
        tick = m_run && (m_pre == TD - 1);
        adv = m_run ? tick : sp;
        if (m_run) m_pre = tick ? 0 : m_pre + 1;
        if (adv) m_pos = dir ? (m_pos + 1) % 16 : (m_pos + 15) % 16;
        wrap = adv && (m_pos == 0);
        if (wrap && msg_load) begin
            m_act = {message1, message2}; m_valid = 1; m_pend = 0;
        end else begin
            if (m_pend && (wrap || !m_valid)) begin
                m_act = m_pbuf; m_valid = 1; m_pend = 0;
            end
            if (msg_load) begin
                m_pbuf = {message1, message2}; m_pend = 1;
            end
        end
        if (mp) begin
            m_run = !m_run;
            if (m_run) m_pre = 0;
        end
        for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? mode_btn : step_btn;
            for (int i = 0; i < DB + 1; i++) hist[b][i] = hist[b][i+1];
            hist[b][DB+1] = raw;
            all_diff = 1;
            for (int i = 0; i < DB; i++) if (hist[b][i] == acc[b]) all_diff = 0;
            pul[b] = all_diff && !acc[b];
            if (all_diff) acc[b] = !acc[b];
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    task automatic set_btn(input bit which, input bit v);
        if (which) step_btn = v; else mode_btn = v;
    endtask

    task automatic press(input bit which, input bit bounce);
        if (bounce) begin
            repeat (2) begin
                set_btn(which, 1); cyc(); cyc();
                set_btn(which, 0); cyc(); cyc();
            end
        end
        set_btn(which, 1); repeat (6) cyc();
        set_btn(which, 0); repeat (6) cyc();
    endtask

    task automatic test_reset();
        reset = 0;
        model_reset();
        #1;
        total++;
        if (obs !== 22'h0) begin bad++; $display("FAIL reset_state obs=%h exp=0", obs); end
        cyc(); cyc();
        reset = 1;
        message1 = 32'h01234567; message2 = 32'h89ABCDEF; msg_load = 1;
        cyc();
        msg_load = 0;
        total++;
        if (pending !== 1'b1) begin bad++; $display("FAIL load_pending obs=%b exp=1", pending); end
        cyc();
        total++;
        if (obs !== {16'h3210, 4'h0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL first_commit obs=%h exp=%h", obs, {16'h3210, 6'h0});
        end
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL first_commit_model obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_step();
        dir = 1;
        repeat (5) begin
            press(1, 0);
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL step_model obs=%h exp=%h", obs, expv()); end
        end
        total++;
        if ({hex3, hex2, hex1, hex0, pos} !== 20'h87655) begin
            bad++; $display("FAIL step5 obs=%h exp=87655", {hex3, hex2, hex1, hex0, pos});
        end
        press(1, 1);
        total++;
        if (pos !== 4'd6) begin bad++; $display("FAIL bounce_step pos=%0d exp=6", pos); end
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL bounce_model obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_run();
        int gap, ticks, n;
        logic [3:0] last;
        dir = 1;
        press(0, 0);
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL run_enter running=%b exp=1", running); end
        n = 0;
        while (pos !== 4'd0 && n < 200) begin
            cyc(); n++;
            total++;
            if (obs !== expv()) begin bad++; $display("FAIL run_model obs=%h exp=%h", obs, expv()); end
        end
        if (n >= 200) begin total++; bad++; $display("FAIL run_wait0 timeout pos=%0d exp=0", pos); end
        gap = 0; ticks = 0; last = pos; n = 0;
        while (ticks < 16 && n < 100) begin
            cyc(); gap++; n++;
            if (pos !== last) begin
                total++;
                if (gap != TD) begin bad++; $display("FAIL tick_gap gap=%0d exp=%0d", gap, TD); end
                if (pos == 4'd15) begin
                    total++;
                    if ({hex3, hex2, hex1, hex0} !== 16'h210F) begin
                        bad++; $display("FAIL run_pos15 hex=%h exp=210F", {hex3, hex2, hex1, hex0});
                    end
                end
                ticks++; gap = 0; last = pos;
            end
        end
        total++;
        if (ticks != 16 || pos !== 4'd0) begin
            bad++; $display("FAIL run_wrap ticks=%0d pos=%0d exp=16,0", ticks, pos);
        end
    endtask

    task automatic test_backward();
        int n;
        press(0, 0);
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL hold_enter running=%b exp=0", running); end
        dir = 1; n = 0;
        while (pos !== 4'd0 && n < 20) begin press(1, 0); n++; end
        dir = 0;
        press(1, 0);
        total++;
        if ({hex3, hex2, hex1, hex0, pos} !== 20'h210FF) begin
            bad++; $display("FAIL back_wrap obs=%h exp=210FF", {hex3, hex2, hex1, hex0, pos});
        end
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL back_model obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_pending();
        int n;
        dir = 1;
        press(0, 0);
        n = 0;
        while (pos !== 4'd14 && n < 200) begin cyc(); n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL pend_wait14 timeout pos=%0d", pos); end
        message1 = 32'hAAAAAAAA; msg_load = 1;
        cyc();
        msg_load = 0;
        total++;
        if (pending !== 1'b1) begin bad++; $display("FAIL pend_set obs=%b exp=1", pending); end
        n = 0;
        while (pos !== 4'd15 && n < 20) begin cyc(); n++; end
        total++;
        if ({hex3, hex2, hex1, hex0, pending} !== 17'h0421F) begin
            bad++; $display("FAIL pend_hold obs=%h exp=0421F", {hex3, hex2, hex1, hex0, pending});
        end
        n = 0;
        while (pos !== 4'd0 && n < 20) begin cyc(); n++; end
        total++;
        if ({hex3, hex2, hex1, hex0, pending} !== {16'hAAAA, 1'b0}) begin
            bad++; $display("FAIL pend_commit obs=%h exp=%h", {hex3, hex2, hex1, hex0, pending}, {16'hAAAA, 1'b0});
        end
        total++;
        if (obs !== expv()) begin bad++; $display("FAIL pend_model obs=%h exp=%h", obs, expv()); end
    endtask

    task automatic test_reset_mid();
        message1 = $urandom; message2 = $urandom; msg_load = 1;
        cyc();
        msg_load = 0;
        total++;
        if ({running, pending} !== 2'b11) begin
            bad++; $display("FAIL mid_pre obs=%b exp=11", {running, pending});
        end
        reset = 0;
        #1;
        model_reset();
        total++;
        if (obs !== 22'h0) begin bad++; $display("FAIL mid_reset obs=%h exp=0", obs); end
        cyc();
        reset = 1;
        mode_btn = 1;
        repeat (3) cyc();
        reset = 0;
        #1;
        model_reset();
        mode_btn = 0;
        cyc();
        reset = 1;
        repeat (10) cyc();
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL partial_press running=%b exp=0", running); end
    endtask

    task automatic test_random();
        message1 = $urandom; message2 = $urandom; msg_load = 1;
        cyc();
        msg_load = 0;
        for (int i = 0; i < 600; i++) begin
            dir = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 2) == 0) step_btn = ~step_btn;
            msg_load = ($urandom_range(0, 19) == 0);
            if (msg_load) begin message1 = $urandom; message2 = $urandom; end
            cyc();
            total++;
            if (obs !== expv()) begin
                bad++; $display("FAIL random_model cyc=%0d obs=%h exp=%h", i, obs, expv());
            end
        end
        msg_load = 0; mode_btn = 0; step_btn = 0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_backward();
        test_pending();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
